// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: WB result-select encodings,
// load funct3 codes and the writeback FSM state type.
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load extraction: picks byte/half/word lane from an aligned word
// and extends it; flags misaligned or undefined load types.
//   funct3, addr[1:0], rdata -> data (32b), misaligned
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[7:0];
        case (addr)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
    end

    assign h = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data       = 32'd0;
        misaligned = 1'b0;
        unique case (funct3)
            F3_LB:  data = {{24{b[7]}}, b};
            F3_LBU: data = {24'd0, b};
            F3_LH: begin
                data       = {{16{h[15]}}, h};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {16'd0, h};
                misaligned = addr[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// WB stage: accepts retiring instructions from MEM, waits for load
// data, and drives the register-file write port (WE3/A3/WD3).
//   clk, rst (async, active-low)
//   mem_*      : MEM->WB bundle with valid/ready handshake
//   dmem_*     : data-memory read return
//   rf_*       : registered write port, also used for forwarding
//   load_err   : one-cycle pulse on misaligned / timed-out load
//   retired    : completed-instruction counter
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_result_src,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_pc_plus4,
    input  logic [2:0]       mem_funct3,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_addr,
    output logic [31:0]      rf_wdata,
    output logic             load_err,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(LOAD_TIMEOUT - 1);

    wb_state_t     state;
    logic [TW-1:0] cnt;
    logic          cap_rw;
    logic [4:0]    cap_rd;
    logic [2:0]    cap_f3;
    logic [1:0]    cap_addr;

    logic          accept;
    logic          is_load;
    logic [2:0]    la_f3;
    logic [1:0]    la_addr;
    logic [31:0]   la_data;
    logic          la_mis;
    logic [31:0]   nonload_wd;
    logic          unused_addr;

    assign unused_addr = ^mem_alu_result[31:2];

    assign mem_ready = rst && (state == WB_IDLE);
    assign accept    = mem_valid && mem_ready;
    assign is_load   = (mem_result_src == RESULT_LOAD);

    // One aligner serves both uses: the alignment check on the
    // incoming op in IDLE, and extraction of the captured load.
    assign la_f3   = (state == WB_IDLE) ? mem_funct3 : cap_f3;
    assign la_addr = (state == WB_IDLE) ? mem_alu_result[1:0] : cap_addr;

    load_align u_align (
        .funct3     (la_f3),
        .addr       (la_addr),
        .rdata      (dmem_rdata),
        .data       (la_data),
        .misaligned (la_mis)
    );

    // Reserved encoding 11 falls through to the ALU result.
    assign nonload_wd = (mem_result_src == RESULT_PC4) ?
                        mem_pc_plus4 : mem_alu_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WB_IDLE;
            cnt      <= '0;
            cap_rw   <= 1'b0;
            cap_rd   <= 5'd0;
            cap_f3   <= 3'd0;
            cap_addr <= 2'd0;
            rf_we    <= 1'b0;
            rf_addr  <= 5'd0;
            rf_wdata <= 32'd0;
            load_err <= 1'b0;
            retired  <= '0;
        end else begin
            rf_we    <= 1'b0;
            load_err <= 1'b0;
            unique case (state)
                WB_IDLE: begin
                    if (accept && is_load) begin
                        if (la_mis) begin
                            load_err <= 1'b1;
                        end else begin
                            state    <= WB_WAIT_LOAD;
                            cnt      <= '0;
                            cap_rw   <= mem_reg_write;
                            cap_rd   <= mem_rd;
                            cap_f3   <= mem_funct3;
                            cap_addr <= mem_alu_result[1:0];
                        end
                    end else if (accept) begin
                        retired <= retired + 1'b1;
                        if (mem_reg_write && mem_rd != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_addr  <= mem_rd;
                            rf_wdata <= nonload_wd;
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    // Data arriving on the last allowed cycle still wins.
                    if (dmem_rvalid) begin
                        state   <= WB_IDLE;
                        retired <= retired + 1'b1;
                        if (cap_rw && cap_rd != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_addr  <= cap_rd;
                            rf_wdata <= la_data;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state    <= WB_IDLE;
                        load_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for single ops and
// loads, plus hand sequences for timeout, stall and reset cases.
module tb_writeback_unit;
    import riscv_pkg::*;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic [1:0]  mem_result_src = 2'd0;
    logic [31:0] mem_alu_result = 32'd0;
    logic [31:0] mem_pc_plus4 = 32'd0;
    logic [2:0]  mem_funct3 = 3'd0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        load_err;
    logic [31:0] retired;

    writeback_unit #(.LOAD_TIMEOUT(T), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_result_src (mem_result_src),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_funct3     (mem_funct3),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rf_we          (rf_we),
        .rf_addr        (rf_addr),
        .rf_wdata       (rf_wdata),
        .load_err       (load_err),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          dly;
        logic        ewe;
        logic [31:0] ewd;
        logic        eerr;
    } vec_t;

    vec_t        v[16];
    int          nvec = 0;
    int          nmis = 0;
    int          exp_ret = 0;
    logic [4:0]  last_addr = 5'd0;
    logic [31:0] last_wd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic we,
                           input logic err);
        chk({tag, ".we"},   32'(rf_we), 32'(we));
        chk({tag, ".err"},  32'(load_err), 32'(err));
        chk({tag, ".addr"}, 32'(rf_addr), 32'(last_addr));
        chk({tag, ".wd"},   rf_wdata, last_wd);
        chk({tag, ".ret"},  retired, 32'(exp_ret));
        chk({tag, ".rdy"},  32'(mem_ready), 32'd1);
    endtask

    task automatic drive(input logic [1:0] src, input logic rw,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3);
        mem_valid      = 1'b1;
        mem_result_src = src;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_pc_plus4   = pc4;
        mem_funct3     = f3;
    endtask

    task automatic note_write(input logic [4:0] rd, input logic [31:0] wd);
        last_addr = rd;
        last_wd   = wd;
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        drive(x.src, x.rw, x.rd, x.alu, x.pc4, x.f3);
        @(negedge clk);
        mem_valid = 1'b0;
        if (x.src == RESULT_LOAD && !x.eerr) begin
            for (int k = 1; k <= x.dly; k++) begin
                chk({tag, ".stall"}, 32'(mem_ready), 32'd0);
                dmem_rvalid = (k == x.dly);
                dmem_rdata  = x.rdata;
                if (k < x.dly) @(negedge clk);
            end
            @(negedge clk);
            dmem_rvalid = 1'b0;
        end
        if (!x.eerr) exp_ret++;
        if (x.ewe) note_write(x.rd, x.ewd);
        chk_out(tag, x.ewe, x.eerr);
    endtask

    initial begin
        int k;
        v[0]  = '{RESULT_ALU,  1, 5'd5,  32'hDEADBEEF, 0, 0, 0, 0,
                  1, 32'hDEADBEEF, 0};
        v[1]  = '{RESULT_LOAD, 1, 5'd6,  32'h1003, 0, F3_LB,
                  32'h80FF0000, 3, 1, 32'hFFFFFF80, 0};
        v[2]  = '{RESULT_LOAD, 1, 5'd7,  32'h1003, 0, F3_LBU,
                  32'h80FF0000, 3, 1, 32'h00000080, 0};
        v[3]  = '{RESULT_LOAD, 1, 5'd8,  32'h1002, 0, F3_LW,
                  32'h11111111, 1, 0, 0, 1};
        v[4]  = '{RESULT_LOAD, 1, 5'd8,  32'h1002, 0, F3_LH,
                  32'h80011234, 1, 1, 32'hFFFF8001, 0};
        v[5]  = '{RESULT_LOAD, 1, 5'd9,  32'h1000, 0, F3_LHU,
                  32'h8001F234, 2, 1, 32'h0000F234, 0};
        v[6]  = '{RESULT_LOAD, 1, 5'd10, 32'h2000, 0, F3_LW,
                  32'h12345678, 1, 1, 32'h12345678, 0};
        v[7]  = '{RESULT_LOAD, 1, 5'd11, 32'h1001, 0, F3_LH,
                  0, 1, 0, 0, 1};
        v[8]  = '{RESULT_LOAD, 1, 5'd11, 32'h0, 0, 3'b011,
                  0, 1, 0, 0, 1};
        v[9]  = '{RESULT_PC4,  1, 5'd1,  32'h5555, 32'h104, 0, 0, 0,
                  1, 32'h104, 0};
        v[10] = '{2'b11,       1, 5'd2,  32'hA5A5, 32'h200, 0, 0, 0,
                  1, 32'hA5A5, 0};
        v[11] = '{RESULT_PC4,  1, 5'd0,  32'h0, 32'h300, 0, 0, 0,
                  0, 0, 0};
        v[12] = '{RESULT_ALU,  0, 5'd3,  32'h77, 0, 0, 0, 0,
                  0, 0, 0};
        v[13] = '{RESULT_LOAD, 1, 5'd11, 32'h1001, 0, F3_LB,
                  32'h00007F00, 2, 1, 32'h0000007F, 0};
        v[14] = '{RESULT_LOAD, 1, 5'd12, 32'h1003, 0, F3_LHU,
                  0, 1, 0, 0, 1};
        v[15] = '{RESULT_LOAD, 1, 5'd0,  32'h1000, 0, F3_LB,
                  32'hFFFFFFFF, 1, 0, 0, 0};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst.we",  32'(rf_we), 32'd0);
        chk("rst.addr", 32'(rf_addr), 32'd0);
        chk("rst.wd",  rf_wdata, 32'd0);
        chk("rst.err", 32'(load_err), 32'd0);
        chk("rst.ret", retired, 32'd0);
        chk("rst.rdy", 32'(mem_ready), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) apply(v[i], $sformatf("vec%0d", i));

        // back-to-back ALU writes to rd 1,2,3
        @(negedge clk);
        drive(RESULT_ALU, 1, 5'd1, 32'h101, 0, 0);
        @(negedge clk);
        exp_ret++; note_write(5'd1, 32'h101);
        chk_out("b2b1", 1, 0);
        drive(RESULT_ALU, 1, 5'd2, 32'h202, 0, 0);
        @(negedge clk);
        exp_ret++; note_write(5'd2, 32'h202);
        chk_out("b2b2", 1, 0);
        drive(RESULT_ALU, 1, 5'd3, 32'h303, 0, 0);
        @(negedge clk);
        mem_valid = 1'b0;
        exp_ret++; note_write(5'd3, 32'h303);
        chk_out("b2b3", 1, 0);

        // timeout: abort visible T+1 cycles after accept
        @(negedge clk);
        drive(RESULT_LOAD, 1, 5'd4, 32'h0, 0, F3_LW);
        @(negedge clk);
        mem_valid = 1'b0;
        k = 1;
        while (!load_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo.cycles", 32'(k), 32'(T + 1));
        chk_out("tmo", 0, 1);

        // rvalid on the final allowed cycle beats the timeout
        @(negedge clk);
        drive(RESULT_LOAD, 1, 5'd4, 32'h0, 0, F3_LW);
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (T - 1) @(negedge clk);
        chk("edge.stall", 32'(mem_ready), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0BADF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        exp_ret++; note_write(5'd4, 32'h0BADF00D);
        chk_out("edge", 1, 0);

        // rvalid in IDLE ignored
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk_out("idle_rv", 0, 0);

        // rvalid and mem_valid together in WAIT_LOAD
        @(negedge clk);
        drive(RESULT_LOAD, 1, 5'd12, 32'h10, 0, F3_LW);
        @(negedge clk);
        drive(RESULT_ALU, 1, 5'd13, 32'h1313, 0, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        chk("sim.stall", 32'(mem_ready), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        exp_ret++; note_write(5'd12, 32'hCAFEF00D);
        chk_out("sim.ld", 1, 0);
        @(negedge clk);
        mem_valid = 1'b0;
        exp_ret++; note_write(5'd13, 32'h1313);
        chk_out("sim.alu", 1, 0);

        // reset during WAIT_LOAD drops the load
        @(negedge clk);
        drive(RESULT_LOAD, 1, 5'd14, 32'h0, 0, F3_LB);
        @(negedge clk);
        mem_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst.addr", 32'(rf_addr), 32'd0);
        chk("arst.wd",  rf_wdata, 32'd0);
        chk("arst.ret", retired, 32'd0);
        chk("arst.rdy", 32'(mem_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
        note_write(5'd0, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk_out("arst.post", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
